// File: rtl/pulse_seq_pkg.sv
// Shared definitions for the pulse sequencer: phase encoding, state enum, duration width default.
package pulse_seq_pkg;
  localparam int CW_DEFAULT = 24;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_DELAY = 3'd1, S_RISE = 3'd2,
    S_HIGH = 3'd3, S_FALL  = 3'd4, S_LOW  = 3'd5
  } state_e;

  localparam logic [2:0] ST_IDLE  = S_IDLE;
  localparam logic [2:0] ST_DELAY = S_DELAY;
  localparam logic [2:0] ST_RISE  = S_RISE;
  localparam logic [2:0] ST_HIGH  = S_HIGH;
  localparam logic [2:0] ST_FALL  = S_FALL;
  localparam logic [2:0] ST_LOW   = S_LOW;

  // First phase at or after s whose duration is nonzero; ST_IDLE means the period is over.
  function automatic logic [2:0] first_nz(input logic [2:0] s, input logic nz_dly,
                                          input logic nz_rise, input logic nz_fall,
                                          input logic nz_low);
    logic [2:0] r;
    r = ST_IDLE;
    if      (s <= ST_DELAY && nz_dly)  r = ST_DELAY;
    else if (s <= ST_RISE  && nz_rise) r = ST_RISE;
    else if (s <= ST_HIGH)             r = ST_HIGH;
    else if (s <= ST_FALL  && nz_fall) r = ST_FALL;
    else if (s <= ST_LOW   && nz_low)  r = ST_LOW;
    return r;
  endfunction
endpackage

// File: rtl/pulse_seq_timer.sv
// Per-phase down counter: load N-1 on phase entry, zero flags the phase's last cycle.
module pulse_seq_timer #(
  parameter int CW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic          zero_o
);
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst)              cnt_q <= '0;
    else if (load_i)      cnt_q <= load_val_i;
    else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/pulse_seq_ctrl.sv
// Pulse sequencer: IDLE -> DELAY -> {RISE, HIGH, FALL, LOW}* with optional linear ramps.
// Define PULSE_SEQ_RAMP_EN to ramp value through RISE/FALL; otherwise edges are steps.
module pulse_seq_ctrl import pulse_seq_pkg::*; #(
  parameter int W  = 16,
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [W-1:0]  cfg_iv,
  input  logic [W-1:0]  cfg_pv,
  input  logic [CW-1:0] cfg_delay,
  input  logic [CW-1:0] cfg_rise,
  input  logic [CW-1:0] cfg_width,
  input  logic [CW-1:0] cfg_fall,
  input  logic [CW-1:0] cfg_period,
  input  logic          cfg_one_shot,
  input  logic [W-1:0]  cfg_step,
  input  logic          start,
  input  logic          stop,
  output logic [W-1:0]  value,
  output logic [2:0]    phase,
  output logic          busy,
  output logic          cycle_done
);
  typedef struct packed {
    logic [W-1:0]  iv;
    logic [W-1:0]  pv;
    logic [CW-1:0] delay;
    logic [CW-1:0] rise;
    logic [CW-1:0] width;
    logic [CW-1:0] fall;
    logic [CW-1:0] period;
    logic          one_shot;
  } cfg_t;

  localparam logic [CW-1:0] ONE = CW'(1);

  cfg_t              cfg_q, cfg_d;
  logic [2:0]        state_q, st_d;
  logic              tmr_load, tmr_zero;
  logic [CW-1:0]     load_val, wid_eff, low_dur;
  logic signed [CW+1:0] low_s;
  logic              nz_dly, nz_rise, nz_fall, nz_low, period_end;

  assign cfg_ready = (state_q == ST_IDLE);
  assign busy      = ~cfg_ready;
  assign phase     = state_q;

  // A start in the same cycle as a config write runs with the new config.
  always_comb begin
    cfg_d = cfg_q;
    if (cfg_valid && cfg_ready)
      cfg_d = '{iv: cfg_iv, pv: cfg_pv, delay: cfg_delay, rise: cfg_rise, width: cfg_width,
                fall: cfg_fall, period: cfg_period, one_shot: cfg_one_shot};
  end

  assign wid_eff = (cfg_d.width == '0) ? ONE : cfg_d.width;
  assign low_s   = $signed({2'b00, cfg_d.period}) - $signed({2'b00, cfg_d.rise})
                 - $signed({2'b00, wid_eff}) - $signed({2'b00, cfg_d.fall});
  assign low_dur = low_s[CW-1:0];
  assign nz_dly  = (cfg_d.delay != '0);
  assign nz_rise = (cfg_d.rise != '0);
  assign nz_fall = (cfg_d.fall != '0);
  assign nz_low  = ~low_s[CW+1] && (low_s != '0);

  assign period_end = busy && tmr_zero &&
                      (first_nz(state_q + 3'd1, nz_dly, nz_rise, nz_fall, nz_low) == ST_IDLE);
  assign cycle_done = period_end;

  always_comb begin
    st_d     = state_q;
    tmr_load = 1'b0;
    if (state_q == ST_IDLE) begin
      if (start && !stop) begin
        st_d     = first_nz(ST_DELAY, nz_dly, nz_rise, nz_fall, nz_low);
        tmr_load = 1'b1;
      end
    end else if (stop) begin
      st_d = ST_IDLE;
    end else if (tmr_zero) begin
      tmr_load = 1'b1;
      if (period_end)
        st_d = cfg_d.one_shot ? ST_IDLE : first_nz(ST_RISE, nz_dly, nz_rise, nz_fall, nz_low);
      else
        st_d = first_nz(state_q + 3'd1, nz_dly, nz_rise, nz_fall, nz_low);
    end
    case (st_d)
      ST_DELAY: load_val = cfg_d.delay - ONE;
      ST_RISE:  load_val = cfg_d.rise - ONE;
      ST_HIGH:  load_val = wid_eff - ONE;
      ST_FALL:  load_val = cfg_d.fall - ONE;
      ST_LOW:   load_val = low_dur - ONE;
      default:  load_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cfg_q   <= '0;
    end else begin
      state_q <= st_d;
      cfg_q   <= cfg_d;
    end
  end

  pulse_seq_timer #(.CW(CW)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (tmr_load),
    .load_val_i(load_val),
    .zero_o    (tmr_zero)
  );

`ifdef PULSE_SEQ_RAMP_EN
  logic [W-1:0]      step_q, ramp_q, ramp_d;
  logic signed [W:0] up_s, dn_s, iv_s, pv_s;

  assign iv_s = $signed({cfg_q.iv[W-1], cfg_q.iv});
  assign pv_s = $signed({cfg_q.pv[W-1], cfg_q.pv});
  assign up_s = $signed({ramp_q[W-1], ramp_q}) + $signed({step_q[W-1], step_q});
  assign dn_s = $signed({ramp_q[W-1], ramp_q}) - $signed({step_q[W-1], step_q});

  // Entry cycle of RISE/FALL shows the starting level; later cycles step and clamp.
  always_comb begin
    ramp_d = ramp_q;
    if (st_d == ST_RISE)
      ramp_d = (state_q != ST_RISE) ? cfg_d.iv : ((up_s >= pv_s) ? cfg_q.pv : up_s[W-1:0]);
    else if (st_d == ST_FALL)
      ramp_d = (state_q != ST_FALL) ? cfg_d.pv : ((dn_s <= iv_s) ? cfg_q.iv : dn_s[W-1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q <= '0;
      ramp_q <= '0;
    end else begin
      if (cfg_valid && cfg_ready) step_q <= cfg_step;
      ramp_q <= ramp_d;
    end
  end

  assign value = (state_q == ST_RISE || state_q == ST_FALL) ? ramp_q :
                 (state_q == ST_HIGH) ? cfg_q.pv : cfg_q.iv;
`else
  logic step_unused;
  assign step_unused = ^cfg_step;
  assign value = (state_q == ST_HIGH || state_q == ST_FALL) ? cfg_q.pv : cfg_q.iv;
`endif
endmodule
